bs_drvr_fifo: RTL and testbench

Per-driver queue pair between one device and the bus generator.
- TX queue: the device writes packets; the bus side sees them through pndng/D_pop/pop.
- RX queue: the bus side delivers packets through push/D_push; the device reads them.
- Also filters misrouted RX packets and keeps saturating drop/error counters. One instance per driver port (DRVRS instances).

---
 rtl/bs_pkg.sv | 25 ++
 rtl/bs_fwft_fifo.sv | 60 ++++++
 rtl/bs_drvr_fifo.sv | 85 ++++++++
 tb/tb_bs_drvr_fifo.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared bus-system definitions: packet layout, address constants and the
// RX routing predicate used by each driver queue pair.
package bs_pkg;

    localparam int         PCKG_SZ   = 128;
    localparam logic [7:0] BROADCAST = 8'hFF;
    localparam int         DRVRS     = 4;

    localparam int TGT_MSB = PCKG_SZ - 1;
    localparam int SRC_MSB = PCKG_SZ - 9;
    localparam int ID_MSB  = PCKG_SZ - 17;

    typedef struct packed {
        logic [7:0]          target;
        logic [7:0]          source;
        logic [15:0]         id;
        logic [PCKG_SZ-33:0] payload;
    } pckt_t;

    function automatic logic is_for_me(input pckt_t pckt, input logic [7:0] id,
                                       input logic [7:0] bcast);
        return (pckt.target == id) || (pckt.target == bcast);
    endfunction

endpackage

// File: rtl/bs_fwft_fifo.sv
// First-word-fall-through FIFO; a write while full is accepted only when a
// read retires the head at the same edge.
module bs_fwft_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign ovf   = wr && full && !rd;
    assign unf   = rd && empty;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd && !empty;
        do_wr    = wr && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never reset: stale entries are masked by the empty check on rdata.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bs_drvr_fifo.sv
// Per-driver TX/RX queue pair with RX address filtering, saturating drop
// counters and a sticky underflow flag.
module bs_drvr_fifo #(
    parameter int         PCKG_SZ   = bs_pkg::PCKG_SZ,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] DRVR_ID   = 8'd0,
    parameter logic [7:0] BROADCAST = bs_pkg::BROADCAST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [PCKG_SZ-1:0] wr_data,
    output logic               wr_full,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    input  logic               rd_en,
    output logic [PCKG_SZ-1:0] rd_data,
    output logic               rd_valid,
    output logic [15:0]        tx_ovf_cnt,
    output logic [15:0]        rx_drop_cnt,
    output logic               underflow
);

    import bs_pkg::*;

    // Handshake: pndng/rd_valid act as valid; pop/rd_en consume the head shown on
    // D_pop/rd_data at the same edge; wr_en/push need no ready and are dropped
    // (and counted) when the queue cannot take them.
    logic        tx_full, tx_empty, tx_ovf, tx_unf;
    logic        rx_full_unused, rx_empty, rx_ovf, rx_unf;
    logic        rx_hit, rx_wr;
    pckt_t       rx_hdr;
    logic [15:0] tx_ovf_cnt_q, tx_ovf_cnt_d;
    logic [15:0] rx_drop_cnt_q, rx_drop_cnt_d;
    logic        underflow_q, underflow_d;

    bs_fwft_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .reset(reset), .wr(wr_en), .wdata(wr_data), .rd(pop),
        .rdata(D_pop), .full(tx_full), .empty(tx_empty), .ovf(tx_ovf), .unf(tx_unf)
    );

    bs_fwft_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .reset(reset), .wr(rx_wr), .wdata(D_push), .rd(rd_en),
        .rdata(rd_data), .full(rx_full_unused), .empty(rx_empty), .ovf(rx_ovf), .unf(rx_unf)
    );

    always_comb begin
        rx_hdr        = '0;
        rx_hdr.target = D_push[PCKG_SZ-1 -: 8];
        rx_hit        = is_for_me(rx_hdr, DRVR_ID, BROADCAST);
        rx_wr         = push && rx_hit;

        tx_ovf_cnt_d  = tx_ovf_cnt_q;
        if (tx_ovf && tx_ovf_cnt_q != 16'hFFFF) tx_ovf_cnt_d = tx_ovf_cnt_q + 16'd1;

        rx_drop_cnt_d = rx_drop_cnt_q;
        if (((push && !rx_hit) || rx_ovf) && rx_drop_cnt_q != 16'hFFFF)
            rx_drop_cnt_d = rx_drop_cnt_q + 16'd1;

        underflow_d   = underflow_q || tx_unf || rx_unf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf_cnt_q  <= '0;
            rx_drop_cnt_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            tx_ovf_cnt_q  <= tx_ovf_cnt_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
            underflow_q   <= underflow_d;
        end
    end

    assign wr_full     = tx_full;
    assign pndng       = !tx_empty;
    assign rd_valid    = !rx_empty;
    assign tx_ovf_cnt  = tx_ovf_cnt_q;
    assign rx_drop_cnt = rx_drop_cnt_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_bs_drvr_fifo.sv
// Self-checking bench for bs_drvr_fifo: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_bs_drvr_fifo;

    localparam int         PW    = 128;
    localparam int         DEPTH = 16;
    localparam logic [7:0] MY_ID = 8'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, pop, push, rd_en;
    logic [PW-1:0] wr_data, D_push;
    logic          wr_full, pndng, rd_valid, underflow;
    logic [PW-1:0] D_pop, rd_data;
    logic [15:0]   tx_ovf_cnt, rx_drop_cnt;

    bs_drvr_fifo #(.PCKG_SZ(PW), .DEPTH(DEPTH), .DRVR_ID(MY_ID), .BROADCAST(8'hFF)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .tx_ovf_cnt(tx_ovf_cnt), .rx_drop_cnt(rx_drop_cnt), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues and counters following the queueing rules.
    logic [PW-1:0] m_tx[$];
    logic [PW-1:0] m_rx[$];
    logic [15:0]   m_tx_ovf, m_rx_drop;
    logic          m_unf;

    function automatic logic [PW-1:0] mk(input logic [7:0] t, input logic [7:0] s,
                                         input logic [15:0] id);
        return {t, s, id, $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_tx_ovf  = '0;
        m_rx_drop = '0;
        m_unf     = 1'b0;
    endtask

    // Drive one clock of stimulus, update the model, and return at edge+1.
    task automatic cycle(input logic w, input logic [PW-1:0] wd, input logic p,
                         input logic ps, input logic [PW-1:0] dp, input logic r);
        logic pop_ok, rd_ok, hit;
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = r;
        pop_ok = p && (m_tx.size() != 0);
        if (p && !pop_ok) m_unf = 1'b1;
        if (pop_ok) void'(m_tx.pop_front());
        if (w) begin
            if (m_tx.size() < DEPTH) m_tx.push_back(wd);
            else m_tx_ovf = sat_inc(m_tx_ovf);
        end
        rd_ok = r && (m_rx.size() != 0);
        if (r && !rd_ok) m_unf = 1'b1;
        if (rd_ok) void'(m_rx.pop_front());
        if (ps) begin
            hit = (dp[PW-1 -: 8] == MY_ID) || (dp[PW-1 -: 8] == 8'hFF);
            if (hit && m_rx.size() < DEPTH) m_rx.push_back(dp);
            else m_rx_drop = sat_inc(m_rx_drop);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL reset_pndng got=%0b exp=0", pndng); end
        n_checks++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_wr_full got=%0b exp=0", wr_full); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        n_checks++; if (D_pop !== '0) begin n_fail++; $display("FAIL reset_D_pop got=%h exp=0", D_pop); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        n_checks++; if (tx_ovf_cnt !== 16'd0 || rx_drop_cnt !== 16'd0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_counters got=%0d/%0d/%0b exp=0/0/0", tx_ovf_cnt, rx_drop_cnt, underflow);
        end
    endtask

    task automatic test_tx_order();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, mk(8'd1, 8'd0, 16'(i)), 1'b0, 1'b0, '0, 1'b0);
            if (i == 0) begin
                n_checks++; if (pndng !== 1'b1) begin n_fail++; $display("FAIL order_pndng_first got=%0b exp=1", pndng); end
                n_checks++; if (D_pop[PW-17 -: 16] !== 16'd0) begin
                    n_fail++; $display("FAIL order_head_first got=%0d exp=0", D_pop[PW-17 -: 16]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (D_pop[PW-17 -: 16] !== 16'(i) || D_pop !== m_tx[0]) begin
                n_fail++; $display("FAIL order_pop%0d got=%h exp id=%0d pkt=%h", i, D_pop, i, m_tx[0]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        n_checks++; if (pndng !== 1'b0 || D_pop !== '0) begin
            n_fail++; $display("FAIL order_drained got pndng=%0b D_pop=%h exp 0/0", pndng, D_pop);
        end
    endtask

    task automatic test_tx_full();
        logic [15:0] exp_id;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, mk(8'd2, 8'd0, 16'(i)), 1'b0, 1'b0, '0, 1'b0);
            if (i == 14) begin
                n_checks++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL full_early got=%0b exp=0", wr_full); end
            end
            if (i == 15) begin
                n_checks++; if (wr_full !== 1'b1 || tx_ovf_cnt !== 16'd0) begin
                    n_fail++; $display("FAIL full_at16 got full=%0b ovf=%0d exp 1/0", wr_full, tx_ovf_cnt);
                end
            end
        end
        n_checks++; if (tx_ovf_cnt !== 16'd1 || wr_full !== 1'b1) begin
            n_fail++; $display("FAIL full_drop17 got ovf=%0d full=%0b exp 1/1", tx_ovf_cnt, wr_full);
        end
        cycle(1'b1, mk(8'd2, 8'd0, 16'h0100), 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (tx_ovf_cnt !== 16'd1 || wr_full !== 1'b1 || D_pop[PW-17 -: 16] !== 16'd1) begin
            n_fail++; $display("FAIL full_wr_pop got ovf=%0d full=%0b head=%0d exp 1/1/1",
                               tx_ovf_cnt, wr_full, D_pop[PW-17 -: 16]);
        end
        for (int i = 0; i < 16; i++) begin
            exp_id = (i < 15) ? 16'(i + 1) : 16'h0100;
            n_checks++; if (D_pop[PW-17 -: 16] !== exp_id || D_pop !== m_tx[0]) begin
                n_fail++; $display("FAIL full_drain%0d got=%h exp id=%0d", i, D_pop, exp_id);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        n_checks++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL full_empty_after got=%0b exp=0", pndng); end
    endtask

    task automatic test_rx_filter();
        cycle(1'b0, '0, 1'b0, 1'b1, mk(8'd1, 8'd5, 16'd10), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, mk(8'hFF, 8'd5, 16'd11), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, mk(8'd2, 8'd5, 16'd12), 1'b0);
        n_checks++; if (rd_valid !== 1'b1 || rd_data[PW-1 -: 8] !== 8'd1 || rd_data !== m_rx[0]) begin
            n_fail++; $display("FAIL rx_head_tgt1 got valid=%0b data=%h exp tgt=01", rd_valid, rd_data);
        end
        n_checks++; if (rx_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL rx_drop got=%0d exp=1", rx_drop_cnt); end
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_checks++; if (rd_data[PW-1 -: 8] !== 8'hFF || rd_data[PW-17 -: 16] !== 16'd11) begin
            n_fail++; $display("FAIL rx_head_bcast got=%h exp tgt=ff id=11", rd_data);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin
            n_fail++; $display("FAIL rx_drained got valid=%0b data=%h exp 0/0", rd_valid, rd_data);
        end
    endtask

    task automatic test_underflow();
        logic [PW-1:0] pk;
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_initial got=%0b exp=0", underflow); end
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (underflow !== 1'b1 || pndng !== 1'b0) begin
            n_fail++; $display("FAIL unf_pop_empty got unf=%0b pndng=%0b exp 1/0", underflow, pndng);
        end
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got=%0b exp=1", underflow); end
        pk = mk(8'd3, 8'd1, 16'h0042);
        cycle(1'b1, pk, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (pndng !== 1'b1 || D_pop !== pk) begin
            n_fail++; $display("FAIL unf_wr_pop_empty got pndng=%0b D_pop=%h exp 1/%h", pndng, D_pop, pk);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, mk(8'd3, 8'd1, 16'd1), 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        n_checks++; if (underflow !== 1'b0 || pndng !== 1'b0) begin
            n_fail++; $display("FAIL unf_cleared got unf=%0b pndng=%0b exp 0/0", underflow, pndng);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL unf_rd_empty got unf=%0b valid=%0b exp 1/0", underflow, rd_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] pk;
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(8'd2, 8'd0, 16'(i)), 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, mk(8'd7, 8'd0, 16'd0), 1'b0);
        n_checks++; if (pndng !== 1'b1 || rx_drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL areset_pre got pndng=%0b drop=%0d exp 1/1", pndng, rx_drop_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #2;
        n_checks++; if (pndng !== 1'b0 || D_pop !== '0 || wr_full !== 1'b0) begin
            n_fail++; $display("FAIL areset_tx got pndng=%0b D_pop=%h exp 0/0", pndng, D_pop);
        end
        n_checks++; if (tx_ovf_cnt !== 16'd0 || rx_drop_cnt !== 16'd0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL areset_cnt got %0d/%0d/%0b exp 0/0/0", tx_ovf_cnt, rx_drop_cnt, underflow);
        end
        #2;
        reset = 1'b0;
        model_reset();
        pk = mk(8'd2, 8'd3, 16'hBEEF);
        cycle(1'b1, pk, 1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (D_pop !== pk || D_pop[PW-17 -: 16] !== 16'hBEEF) begin
            n_fail++; $display("FAIL areset_newhead got=%h exp=%h", D_pop, pk);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_loopback();
        int sent, got;
        logic w, p, r;
        logic [PW-1:0] dp;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 1000 && got < 100; c++) begin
            w  = (sent < 100);
            p  = (m_tx.size() != 0);
            dp = p ? m_tx[0] : '0;
            r  = (m_rx.size() != 0);
            if (r) begin
                n_checks++; if (rd_data[PW-17 -: 16] !== 16'(got) || rd_data[PW-1 -: 8] !== MY_ID) begin
                    n_fail++; $display("FAIL loop_rx%0d got=%h exp id=%0d", got, rd_data, got);
                end
                got++;
            end
            cycle(w, mk(MY_ID, 8'd0, 16'(sent)), p, p, dp, r);
            if (w) sent++;
        end
        n_checks++; if (got !== 100) begin n_fail++; $display("FAIL loop_count got=%0d exp=100", got); end
        n_checks++; if (tx_ovf_cnt !== 16'd0 || rx_drop_cnt !== 16'd0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL loop_clean got %0d/%0d/%0b exp 0/0/0", tx_ovf_cnt, rx_drop_cnt, underflow);
        end
    endtask

    task automatic test_random();
        logic w, p, ps, r;
        logic [7:0] tgt;
        logic [PW-1:0] exp_dpop, exp_rd;
        for (int c = 0; c < 600; c++) begin
            exp_dpop = (m_tx.size() != 0) ? m_tx[0] : '0;
            exp_rd   = (m_rx.size() != 0) ? m_rx[0] : '0;
            n_checks++; if (pndng !== (m_tx.size() != 0) || wr_full !== (m_tx.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_tx_flags c=%0d got pndng=%0b full=%0b exp size=%0d", c, pndng, wr_full, m_tx.size());
            end
            n_checks++; if (D_pop !== exp_dpop) begin
                n_fail++; $display("FAIL rnd_D_pop c=%0d got=%h exp=%h", c, D_pop, exp_dpop);
            end
            n_checks++; if (rd_valid !== (m_rx.size() != 0) || rd_data !== exp_rd) begin
                n_fail++; $display("FAIL rnd_rx c=%0d got valid=%0b data=%h exp=%h", c, rd_valid, rd_data, exp_rd);
            end
            n_checks++; if (tx_ovf_cnt !== m_tx_ovf || rx_drop_cnt !== m_rx_drop || underflow !== m_unf) begin
                n_fail++; $display("FAIL rnd_cnt c=%0d got %0d/%0d/%0b exp %0d/%0d/%0b", c,
                                   tx_ovf_cnt, rx_drop_cnt, underflow, m_tx_ovf, m_rx_drop, m_unf);
            end
            if (((c / 150) % 2) == 0) begin
                w = ($urandom_range(0, 9) < 7); p = ($urandom_range(0, 9) < 3);
                ps = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3); p = ($urandom_range(0, 9) < 7);
                ps = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 7);
            end
            case ($urandom_range(0, 3))
                0: tgt = MY_ID;
                1: tgt = 8'hFF;
                2: tgt = 8'd2;
                default: tgt = 8'($urandom_range(0, 255));
            endcase
            cycle(w, mk(8'($urandom_range(0, 255)), 8'd1, 16'(c)), p, ps, mk(tgt, 8'd2, 16'(c)), r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
        wr_data = '0; D_push = '0;
        model_reset();
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_filter();
        test_underflow();
        test_async_reset();
        test_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
